// File: rtl/estacao_pkg.sv
// Shared opcodes, tag constants and FSM encoding for the R-type reservation station.
package estacao_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int unsigned TAG_NONE = 0;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StRelease
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/estacao_reserva_r_seletor_prioridade.sv
// Lowest-index priority encoder: reports whether any request is set and the index of the lowest.
module seletor_prioridade #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/estacao_reserva_r.sv
// R-type reservation station: issue, CDB snoop and single-FU dispatch handshake.
// Optional macro ESTACAO_TIMEOUT_EN adds an EXEC watchdog and the error output.
module estacao_reserva_r
  import estacao_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 3,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned TAG_W     = 3,
  parameter int unsigned BASE_TAG  = 1
`ifdef ESTACAO_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT   = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [2:0]        issue_op,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  output logic [2:0]        fu_op,
  output logic              ready_to_uf,
  output logic              fu_clear,
  input  logic              fu_done,
  output logic [TAG_W-1:0]  exec_tag,
`ifdef ESTACAO_TIMEOUT_EN
  output logic              error,
`endif
  output logic [2:0]        count
);

  localparam int unsigned IDX_W = 3;
  localparam logic [TAG_W-1:0] TagNone = TAG_W'(TAG_NONE);

  logic [N_ENTRIES-1:0] valid_q, valid_d;
  logic [2:0]           op_q [N_ENTRIES];
  logic [2:0]           op_d [N_ENTRIES];
  logic [DATA_W-1:0]    vj_q [N_ENTRIES];
  logic [DATA_W-1:0]    vj_d [N_ENTRIES];
  logic [DATA_W-1:0]    vk_q [N_ENTRIES];
  logic [DATA_W-1:0]    vk_d [N_ENTRIES];
  logic [TAG_W-1:0]     qj_q [N_ENTRIES];
  logic [TAG_W-1:0]     qj_d [N_ENTRIES];
  logic [TAG_W-1:0]     qk_q [N_ENTRIES];
  logic [TAG_W-1:0]     qk_d [N_ENTRIES];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ex_idx_q, ex_idx_d;
  logic [DATA_W-1:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic [2:0]        fu_op_q, fu_op_d;
  logic              rdy_q, rdy_d, clr_q, clr_d;
  logic [TAG_W-1:0]  exec_tag_q, exec_tag_d;
  logic [2:0]        count_q, count_d;

  logic [N_ENTRIES-1:0] ready_vec;
  logic                 free_any, rdy_any;
  logic [IDX_W-1:0]     free_idx, rdy_idx;
  logic                 accept, release_now, done_eff;

  for (genvar g = 0; g < int'(N_ENTRIES); g++) begin : g_ready
    assign ready_vec[g] = valid_q[g] && (qj_q[g] == TagNone) && (qk_q[g] == TagNone);
  end

  seletor_prioridade #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_sel_free (
    .req (~valid_q),
    .any (free_any),
    .idx (free_idx)
  );

  seletor_prioridade #(.N(N_ENTRIES), .IDX_W(IDX_W)) u_sel_ready (
    .req (ready_vec),
    .any (rdy_any),
    .idx (rdy_idx)
  );

  assign issue_ready = free_any;
  assign issue_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
  assign accept      = issue_valid && issue_ready && is_legal_op(issue_op);

`ifdef ESTACAO_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
  logic             timeout_hit;

  assign timeout_hit = (state_q == StExec) && (tmo_q == TMO_W'(TIMEOUT - 1));
  assign tmo_d       = (state_q == StExec) ? tmo_q + TMO_W'(1) : '0;
  assign done_eff    = fu_done || timeout_hit;
  assign error       = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`else
  assign done_eff = fu_done;
`endif

  always_comb begin
    state_d     = state_q;
    ex_idx_d    = ex_idx_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_op_d     = fu_op_q;
    rdy_d       = rdy_q;
    clr_d       = 1'b0;
    exec_tag_d  = exec_tag_q;
    release_now = 1'b0;
`ifdef ESTACAO_TIMEOUT_EN
    err_d       = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (rdy_any) begin
          for (int i = 0; i < int'(N_ENTRIES); i++) begin
            if (rdy_idx == IDX_W'(i)) begin
              fu_a_d  = vj_q[i];
              fu_b_d  = vk_q[i];
              fu_op_d = op_q[i];
            end
          end
          ex_idx_d   = rdy_idx;
          exec_tag_d = TAG_W'(BASE_TAG) + TAG_W'(rdy_idx);
          rdy_d      = 1'b1;
          state_d    = StExec;
        end
      end
      StExec: begin
        if (done_eff) begin
          rdy_d       = 1'b0;
          clr_d       = 1'b1;
          release_now = 1'b1;
          state_d     = StRelease;
`ifdef ESTACAO_TIMEOUT_EN
          err_d       = !fu_done;
`endif
        end
      end
      StRelease: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    op_d    = op_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    for (int i = 0; i < int'(N_ENTRIES); i++) begin
      if (valid_q[i] && cdb_valid && cdb_tag != TagNone) begin
        if (qj_q[i] == cdb_tag) begin
          vj_d[i] = cdb_data;
          qj_d[i] = TagNone;
        end
        if (qk_q[i] == cdb_tag) begin
          vk_d[i] = cdb_data;
          qk_d[i] = TagNone;
        end
      end
      // Operands whose producer broadcasts this very cycle are taken straight off the CDB.
      if (accept && free_idx == IDX_W'(i)) begin
        valid_d[i] = 1'b1;
        op_d[i]    = issue_op;
        if (cdb_valid && issue_qj != TagNone && issue_qj == cdb_tag) begin
          vj_d[i] = cdb_data;
          qj_d[i] = TagNone;
        end else begin
          vj_d[i] = issue_vj;
          qj_d[i] = issue_qj;
        end
        if (cdb_valid && issue_qk != TagNone && issue_qk == cdb_tag) begin
          vk_d[i] = cdb_data;
          qk_d[i] = TagNone;
        end else begin
          vk_d[i] = issue_vk;
          qk_d[i] = issue_qk;
        end
      end
      if (release_now && ex_idx_q == IDX_W'(i)) valid_d[i] = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({accept, release_now})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      state_q    <= StIdle;
      ex_idx_q   <= '0;
      fu_a_q     <= '0;
      fu_b_q     <= '0;
      fu_op_q    <= OP_NOP;
      rdy_q      <= 1'b0;
      clr_q      <= 1'b0;
      exec_tag_q <= '0;
      count_q    <= '0;
      for (int i = 0; i < int'(N_ENTRIES); i++) begin
        op_q[i] <= OP_NOP;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      state_q    <= state_d;
      ex_idx_q   <= ex_idx_d;
      fu_a_q     <= fu_a_d;
      fu_b_q     <= fu_b_d;
      fu_op_q    <= fu_op_d;
      rdy_q      <= rdy_d;
      clr_q      <= clr_d;
      exec_tag_q <= exec_tag_d;
      count_q    <= count_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
    end
  end

  assign fu_a        = fu_a_q;
  assign fu_b        = fu_b_q;
  assign fu_op       = fu_op_q;
  assign ready_to_uf = rdy_q;
  assign fu_clear    = clr_q;
  assign exec_tag    = exec_tag_q;
  assign count       = count_q;

endmodule

// File: tb/tb_estacao_reserva_r.sv
// Directed bench for estacao_reserva_r with a two-cycle-Done FU model.
module tb_estacao_reserva_r;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [2:0]  issue_op = 3'b000;
  logic [15:0] issue_vj = '0, issue_vk = '0;
  logic [2:0]  issue_qj = '0, issue_qk = '0;
  logic        issue_ready;
  logic [2:0]  issue_tag;
  logic        cdb_valid = 1'b0;
  logic [2:0]  cdb_tag = '0;
  logic [15:0] cdb_data = '0;
  logic [15:0] fu_a, fu_b;
  logic [2:0]  fu_op;
  logic        ready_to_uf, fu_clear, fu_done;
  logic [2:0]  exec_tag;
  logic [2:0]  count;
`ifdef ESTACAO_TIMEOUT_EN
  logic        error;
`endif

  int vec = 0;
  int miss = 0;
  int clr_cnt = 0;
  logic fu_en = 1'b1;
  int fu_cnt = 0;

  estacao_reserva_r dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_vj    (issue_vj),
    .issue_vk    (issue_vk),
    .issue_qj    (issue_qj),
    .issue_qk    (issue_qk),
    .issue_ready (issue_ready),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .fu_a        (fu_a),
    .fu_b        (fu_b),
    .fu_op       (fu_op),
    .ready_to_uf (ready_to_uf),
    .fu_clear    (fu_clear),
    .fu_done     (fu_done),
    .exec_tag    (exec_tag),
`ifdef ESTACAO_TIMEOUT_EN
    .error       (error),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  // FU model: Done is raised in the second cycle Ready_to_uf is seen high.
  always @(posedge clk) begin
    if (!rst_n || !ready_to_uf) fu_cnt <= 0;
    else fu_cnt <= fu_cnt + 1;
  end
  assign fu_done = fu_en && ready_to_uf && (fu_cnt == 1);

  always @(negedge clk) if (fu_clear) clr_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                       input logic [2:0] qj, input logic [2:0] qk);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_vj    = vj;
    issue_vk    = vk;
    issue_qj    = qj;
    issue_qk    = qk;
  endtask

  task automatic drain();
    int n = 0;
    issue_valid = 1'b0;
    while ((count != 3'd0 || ready_to_uf) && n < 40) begin
      tick();
      n++;
    end
    tick();
    tick();
    vec++;
    if (count !== 3'd0) begin
      miss++;
      $display("FAIL drain_timeout: count got %0d want 0", count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    vec++;
    if (ready_to_uf !== 1'b0 || fu_clear !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1) begin
      miss++;
      $display("FAIL reset_state: rdy=%b clr=%b count=%0d iready=%b want 0 0 0 1",
               ready_to_uf, fu_clear, count, issue_ready);
    end
    vec++;
    if (fu_a !== 16'h0 || fu_b !== 16'h0 || fu_op !== 3'b000 || exec_tag !== 3'd0) begin
      miss++;
      $display("FAIL reset_regs: a=%h b=%h op=%b tag=%0d want 0", fu_a, fu_b, fu_op, exec_tag);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_exec();
    int c0;
    fu_en = 1'b0;
    issue(3'b010, 16'd1, 16'd2, 3'd0, 3'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    vec++;
    if (ready_to_uf !== 1'b1) begin
      miss++;
      $display("FAIL rstx_pre: ready_to_uf got %b want 1", ready_to_uf);
    end
    c0 = clr_cnt;
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if (ready_to_uf !== 1'b0 || count !== 3'd0 || issue_ready !== 1'b1) begin
      miss++;
      $display("FAIL rstx_async: rdy=%b count=%0d iready=%b want 0 0 1",
               ready_to_uf, count, issue_ready);
    end
    tick();
    tick();
    rst_n = 1'b1;
    fu_en = 1'b1;
    tick();
    tick();
    vec++;
    if (clr_cnt !== c0 || ready_to_uf !== 1'b0 || count !== 3'd0) begin
      miss++;
      $display("FAIL rstx_after: clr_pulses=%0d rdy=%b count=%0d want 0 0 0",
               clr_cnt - c0, ready_to_uf, count);
    end
  endtask

  task automatic test_add();
    int c0 = clr_cnt;
    issue(3'b010, 16'd5, 16'd3, 3'd0, 3'd0);
    #1;
    vec++;
    if (issue_tag !== 3'd1 || issue_ready !== 1'b1) begin
      miss++;
      $display("FAIL add_tag: tag=%0d iready=%b want 1 1", issue_tag, issue_ready);
    end
    tick();
    issue_valid = 1'b0;
    vec++;
    if (count !== 3'd1 || ready_to_uf !== 1'b0) begin
      miss++;
      $display("FAIL add_accept: count=%0d rdy=%b want 1 0", count, ready_to_uf);
    end
    tick();
    vec++;
    if (ready_to_uf !== 1'b1 || fu_a !== 16'd5 || fu_b !== 16'd3 || fu_op !== 3'b010 ||
        exec_tag !== 3'd1) begin
      miss++;
      $display("FAIL add_dispatch: rdy=%b a=%0d b=%0d op=%b tag=%0d want 1 5 3 010 1",
               ready_to_uf, fu_a, fu_b, fu_op, exec_tag);
    end
    tick();
    vec++;
    if (fu_clear !== 1'b0 || ready_to_uf !== 1'b1 || fu_a !== 16'd5) begin
      miss++;
      $display("FAIL add_hold: clr=%b rdy=%b a=%0d want 0 1 5", fu_clear, ready_to_uf, fu_a);
    end
    tick();
    vec++;
    if (fu_clear !== 1'b1 || ready_to_uf !== 1'b0 || count !== 3'd0) begin
      miss++;
      $display("FAIL add_release: clr=%b rdy=%b count=%0d want 1 0 0",
               fu_clear, ready_to_uf, count);
    end
    tick();
    vec++;
    if (fu_clear !== 1'b0 || exec_tag !== 3'd1 || clr_cnt - c0 !== 1) begin
      miss++;
      $display("FAIL add_after: clr=%b tag=%0d pulses=%0d want 0 1 1",
               fu_clear, exec_tag, clr_cnt - c0);
    end
    drain();
  endtask

  task automatic test_illegal_op();
    for (int k = 0; k < 4; k++) begin
      logic [2:0] ops [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
      issue(ops[k], 16'd1, 16'd1, 3'd0, 3'd0);
      tick();
      issue_valid = 1'b0;
      vec++;
      if (count !== 3'd0 || ready_to_uf !== 1'b0) begin
        miss++;
        $display("FAIL illegal_op_%b: count=%0d rdy=%b want 0 0", ops[k], count, ready_to_uf);
      end
    end
    tick();
    vec++;
    if (ready_to_uf !== 1'b0) begin
      miss++;
      $display("FAIL illegal_nodispatch: rdy got %b want 0", ready_to_uf);
    end
  endtask

  task automatic test_cdb_capture();
    issue(3'b011, 16'hdead, 16'd2, 3'd5, 3'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    tick();
    tick();
    vec++;
    if (ready_to_uf !== 1'b0 || count !== 3'd1) begin
      miss++;
      $display("FAIL cdb_wait: rdy=%b count=%0d want 0 1", ready_to_uf, count);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 3'd5;
    cdb_data  = 16'h0010;
    tick();
    cdb_valid = 1'b0;
    vec++;
    if (ready_to_uf !== 1'b0) begin
      miss++;
      $display("FAIL cdb_capture_edge: rdy got %b want 0", ready_to_uf);
    end
    tick();
    vec++;
    if (ready_to_uf !== 1'b1 || fu_a !== 16'h0010 || fu_b !== 16'd2 || fu_op !== 3'b011) begin
      miss++;
      $display("FAIL cdb_dispatch: rdy=%b a=%h b=%h op=%b want 1 0010 0002 011",
               ready_to_uf, fu_a, fu_b, fu_op);
    end
    drain();
  endtask

  task automatic test_bypass();
    issue(3'b110, 16'd9, 16'hbeef, 3'd0, 3'd4);
    cdb_valid = 1'b1;
    cdb_tag   = 3'd4;
    cdb_data  = 16'd7;
    tick();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    tick();
    vec++;
    if (ready_to_uf !== 1'b1 || fu_a !== 16'd9 || fu_b !== 16'd7 || fu_op !== 3'b110) begin
      miss++;
      $display("FAIL bypass_dispatch: rdy=%b a=%0d b=%0d op=%b want 1 9 7 110",
               ready_to_uf, fu_a, fu_b, fu_op);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      issue(3'b010, 16'd0, 16'(10 + k), 3'd6, 3'd0);
      #1;
      vec++;
      if (issue_tag !== 3'(k + 1)) begin
        miss++;
        $display("FAIL full_tag%0d: got %0d want %0d", k, issue_tag, k + 1);
      end
      tick();
    end
    vec++;
    if (issue_ready !== 1'b0 || count !== 3'd3) begin
      miss++;
      $display("FAIL full_state: iready=%b count=%0d want 0 3", issue_ready, count);
    end
    tick();
    issue_valid = 1'b0;
    vec++;
    if (count !== 3'd3 || ready_to_uf !== 1'b0) begin
      miss++;
      $display("FAIL full_fourth: count=%0d rdy=%b want 3 0", count, ready_to_uf);
    end
    cdb_valid = 1'b1;
    cdb_tag   = 3'd6;
    cdb_data  = 16'h0020;
    tick();
    cdb_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int n = 0;
      while (!ready_to_uf && n < 10) begin
        tick();
        n++;
      end
      vec++;
      if (ready_to_uf !== 1'b1 || exec_tag !== 3'(k + 1) || fu_a !== 16'h0020 ||
          fu_b !== 16'(10 + k)) begin
        miss++;
        $display("FAIL order%0d: rdy=%b tag=%0d a=%h b=%0d want 1 %0d 0020 %0d",
                 k, ready_to_uf, exec_tag, fu_a, fu_b, k + 1, 10 + k);
      end
      n = 0;
      while (!fu_clear && n < 10) begin
        tick();
        n++;
      end
      vec++;
      if (fu_clear !== 1'b1 || issue_ready !== 1'b1 || count !== 3'(2 - k)) begin
        miss++;
        $display("FAIL order_rel%0d: clr=%b iready=%b count=%0d want 1 1 %0d",
                 k, fu_clear, issue_ready, count, 2 - k);
      end
      tick();
    end
    drain();
  endtask

`ifdef ESTACAO_TIMEOUT_EN
  task automatic test_timeout();
    fu_en = 1'b0;
    issue(3'b111, 16'd4, 16'd4, 3'd0, 3'd0);
    tick();
    issue_valid = 1'b0;
    tick();
    for (int k = 0; k < 7; k++) begin
      tick();
      vec++;
      if (fu_clear !== 1'b0 || ready_to_uf !== 1'b1 || error !== 1'b0) begin
        miss++;
        $display("FAIL tmo_wait%0d: clr=%b rdy=%b err=%b want 0 1 0",
                 k, fu_clear, ready_to_uf, error);
      end
    end
    tick();
    vec++;
    if (fu_clear !== 1'b1 || error !== 1'b1 || count !== 3'd0) begin
      miss++;
      $display("FAIL tmo_fire: clr=%b err=%b count=%0d want 1 1 0", fu_clear, error, count);
    end
    tick();
    vec++;
    if (fu_clear !== 1'b0 || error !== 1'b0) begin
      miss++;
      $display("FAIL tmo_pulse: clr=%b err=%b want 0 0", fu_clear, error);
    end
    fu_en = 1'b1;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_illegal_op();
    test_cdb_capture();
    test_bypass();
    test_back_to_back();
`ifdef ESTACAO_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/estacao_reserva_r.md
Name: estacao_reserva_R

Overview:
- Reservation station for R-type ops (ADD, SUB, SLT, CMP); it is the initiator side of the functional-unit handshake.
- Accepts issued instructions with operand values or producer tags, snoops the CDB for missing operands, and dispatches ready entries to one R-type functional unit.
- Drives the unit's operands, opcode, Ready_to_uf and Clear; waits for its Done, then frees the entry.

Parameters:
N_ENTRIES, 3, number of station entries (1..7)
DATA_W, 16, operand width
TAG_W, 3, producer-tag width; tag 0 means "value present"
BASE_TAG, 1, tag of entry 0; entry i owns tag BASE_TAG+i, never 0
TIMEOUT, 8, cycles allowed for Fu_done (optional feature only)

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
Issue_valid  in  1  issue request
Issue_op  in  3  opcode: 010 ADD, 011 SUB, 110 SLT, 111 CMP
Issue_Vj, Issue_Vk  in  DATA_W  operand values
Issue_Qj, Issue_Qk  in  TAG_W  producer tags, 0 = value valid
Issue_ready  out  1  a free entry exists
Issue_tag  out  TAG_W  tag allocated to the current issue
Cdb_valid  in  1  CDB broadcast valid
Cdb_tag  in  TAG_W  broadcast producer tag
Cdb_data  in  DATA_W  broadcast value
Fu_A, Fu_B  out  DATA_W  operands to the FU
Fu_op  out  3  opcode to the FU
Ready_to_uf  out  1  start/hold execution
Fu_clear  out  1  one-cycle clear to the FU
Fu_done  in  1  FU operation complete
Exec_tag  out  TAG_W  tag of the executing entry, used to tag the CDB result
Count  out  3  number of valid entries

Behaviour:
- Reset low: all entries invalid, FSM=IDLE; Ready_to_uf, Fu_clear, Fu_A, Fu_B, Fu_op, Exec_tag, Count = 0; Issue_ready=1 (N_ENTRIES>0). Reset mid-EXEC drops the in-flight op with no Fu_clear.
- Issue_ready = not all entries valid (registered state only).
- Issue_tag = BASE_TAG + lowest free index.
- Issue accepted when Issue_valid & Issue_ready & legal op. Illegal ops (000, 001, 100, 101) are dropped: no entry allocated, Count unchanged.
- An entry freed in RELEASE is usable by an issue on the next cycle, not the same one.
- CDB capture: each valid entry with Qj==Cdb_tag!=0 and Cdb_valid loads Vj and sets Qj=0; same for Qk.
- CDB bypass on issue: if an issued Qj/Qk matches a same-cycle Cdb_tag, the entry stores Cdb_data with tag 0.
- Entry is ready when Qj==0 and Qk==0.
- FSM:
  - IDLE: if any entry is ready and not executing, select the lowest index. At the edge: latch Fu_A=Vj, Fu_B=Vk, Fu_op, Exec_tag; Ready_to_uf<=1; go to EXEC.
  - EXEC: Ready_to_uf and operands held stable. When Fu_done=1, at the edge: Ready_to_uf<=0, Fu_clear<=1, entry invalidated, go to RELEASE.
  - RELEASE: Fu_clear<=0; Exec_tag held one more cycle; go to IDLE.
- Latency: issue with ready operands at edge k gives Ready_to_uf high from edge k+1. With the FU's two-cycle Done, Fu_clear pulses after edge k+3, and the entry is free at edge k+3.
- Count: +1 on accept, -1 on release. Both in one cycle leaves it unchanged.
- Widths: tag arithmetic is modulo 2^TAG_W; BASE_TAG+N_ENTRIES-1 must be < 2^TAG_W.
- Without the optional feature, CMP waits for Fu_done indefinitely.

Optional Feature:
- Macro ESTACAO_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in EXEC.
  - If Fu_done has not arrived after TIMEOUT cycles, release proceeds as if Fu_done=1, and output Error (1 bit, reset 0) pulses high for one cycle in RELEASE.
  - Covers FU ops that never raise Done.
- Undefined: no counter, no Error port, and EXEC waits indefinitely.

Decomposition:
- Package estacao_pkg: opcode constants (OP_NOP, OP_ADD, OP_SUB, OP_SLT, OP_CMP), TAG_NONE=0, FSM state encoding (IDLE, EXEC, RELEASE), legal-op function.
- Sub-module seletor_prioridade: parameterised lowest-index priority encoder. Instantiated twice: free-entry select and ready-entry select.

Test Plan:
- Reset held low during EXEC, then released -> Ready_to_uf=0, Count=0, Issue_ready=1, no Fu_clear pulse.
- Issue ADD, Vj=5, Vk=3, Qj=Qk=0 -> Issue_tag=1; next edge Ready_to_uf=1, Fu_A=5, Fu_B=3, Fu_op=010, Exec_tag=1; FU model Done after 2 edges -> single Fu_clear pulse, Count 1->0.
- Issue SUB, Qj=5, Vk=2; three cycles later Cdb_valid, tag 5, data 0x0010 -> dispatch next edge with Fu_A=0x0010, Fu_B=2.
- Issue SLT with Qk=4 in the same cycle as CDB tag 4, data 7 -> entry stores Vk=7; Ready_to_uf high next edge.
- Issue three ADDs with Qj=6 (blocked) -> Issue_ready=0, Count=3; a fourth Issue_valid is ignored; CDB tag 6 -> dispatch in order of tags 1, 2, 3; Issue_ready=1 after the first release.
- With ESTACAO_TIMEOUT_EN: issue CMP, Fu_done tied 0 -> after 8 EXEC cycles Fu_clear=1 and Error=1 for one cycle, entry freed.
